pipe_reg: RTL and testbench

Parametrised multi-stage pipeline register that replaces the single-word `register` wherever a datapath needs a stall-able, flush-able delay line. It carries a WIDTH-bit payload plus a valid bit through DEPTH stages. Each stage advances only when the load enable is high. It also reports how many stages hold valid data. It sits between datapath stages (IF/ID, ID/EX, …) and in multi-cycle operand delay paths.

---
 rtl/pipe_reg_if.sv | 25 ++
 rtl/pipe_reg.sv | 55 +++++
 tb/tb_pipe_reg.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_if.sv
// rtl/pipe_reg_if.sv - payload/valid/control bundle between a pipe_reg and its driver
interface pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pin;
  logic             vin;
  logic             ld;
  logic             flush;
  logic [WIDTH-1:0] pout;
  logic             vout;
  logic [CW-1:0]    count;

  modport master (
    output pin, vin, ld, flush,
    input  pout, vout, count
  );

  modport slave (
    input  pin, vin, ld, flush,
    output pout, vout, count
  );
endinterface

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - stall-able, flush-able DEPTH-stage payload+valid delay line with occupancy count
module pipe_reg #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  pipe_reg_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               count_q, count_d;

  // Next state: flush empties every stage, ld shifts one stage, otherwise hold.
  // The count is tracked incrementally; modular CW-bit arithmetic keeps the
  // full-pipe case (count + 1 - 1) correct even when count+1 would wrap.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (bus.flush) begin
      data_d  = {DEPTH{RST_VAL}};
      valid_d = '0;
      count_d = '0;
    end else if (bus.ld) begin
      data_d[0]  = bus.pin;
      valid_d[0] = bus.vin;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      count_d = count_q + CW'(bus.vin) - CW'(valid_q[DEPTH-1]);
    end
  end

  // Stage registers; reset clears immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= {DEPTH{RST_VAL}};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.pout  = data_q[DEPTH-1];
  assign bus.vout  = valid_q[DEPTH-1];
  assign bus.count = count_q;
endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - directed vector table plus reference-queue random run for pipe_reg
module tb_pipe_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_reg_if #(.WIDTH(8), .DEPTH(3)) b3 ();
  pipe_reg_if #(.WIDTH(8), .DEPTH(1)) b1 ();

  pipe_reg #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  pipe_reg #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic       ld;
    logic       flush;
    logic       vin;
    logic [7:0] pin;
    logic [7:0] pout;
    logic       vout;
    logic [1:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic fl, input logic vin, input logic [7:0] pin,
                     input logic [7:0] pout, input logic vout, input logic [1:0] cnt);
    vec_t v;
    v.ld = ld; v.flush = fl; v.vin = vin; v.pin = pin;
    v.pout = pout; v.vout = vout; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic drive3(input logic ld, input logic fl, input logic vin, input logic [7:0] pin);
    b3.ld = ld; b3.flush = fl; b3.vin = vin; b3.pin = pin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    b3.ld = 0; b3.flush = 0; b3.vin = 0; b3.pin = 0;
    b1.ld = 0; b1.flush = 0; b1.vin = 0; b1.pin = 0;

    // streaming 01..04, then 11/22/33
    add(1,0,1,8'h01, 8'hA5,0,1);
    add(1,0,1,8'h02, 8'hA5,0,2);
    add(1,0,1,8'h03, 8'h01,1,3);
    add(1,0,1,8'h04, 8'h02,1,3);
    add(1,0,1,8'h11, 8'h03,1,3);
    add(1,0,1,8'h22, 8'h04,1,3);
    add(1,0,1,8'h33, 8'h11,1,3);
    // stall four cycles with a valid FF offered
    for (int i = 0; i < 4; i++) add(0,0,1,8'hFF, 8'h11,1,3);
    add(1,0,0,8'h00, 8'h22,1,2);
    add(0,1,0,8'h00, 8'hA5,0,0);
    // bubbles
    add(1,0,1,8'h10, 8'hA5,0,1);
    add(1,0,0,8'h20, 8'hA5,0,1);
    add(1,0,1,8'h30, 8'h10,1,2);
    add(1,0,0,8'h40, 8'h20,0,1);
    add(1,0,0,8'h50, 8'h30,1,1);
    // refill to full, then flush together with ld
    add(1,0,1,8'h61, 8'h40,0,1);
    add(1,0,1,8'h62, 8'h50,0,2);
    add(1,0,1,8'h63, 8'h61,1,3);
    add(1,1,1,8'h77, 8'hA5,0,0);
    // empty pipe shifting bubbles; 77 must never surface
    add(1,0,0,8'h00, 8'hA5,0,0);
    add(1,0,0,8'h00, 8'hA5,0,0);
    add(1,0,0,8'h00, 8'h00,0,0);

    // reset state
    #12;
    check("rst_pout3",  b3.pout,  8'hA5);
    check("rst_vout3",  b3.vout,  0);
    check("rst_count3", b3.count, 0);
    check("rst_pout1",  b1.pout,  8'h3C);
    check("rst_vout1",  b1.vout,  0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      drive3(tbl[k].ld, tbl[k].flush, tbl[k].vin, tbl[k].pin);
      check($sformatf("vec%0d_pout", k),  b3.pout,  tbl[k].pout);
      check($sformatf("vec%0d_vout", k),  b3.vout,  tbl[k].vout);
      check($sformatf("vec%0d_count", k), b3.count, tbl[k].cnt);
    end

    // async reset mid-cycle with a full pipe
    drive3(1,0,1,8'hC1);
    drive3(1,0,1,8'hC2);
    drive3(1,0,1,8'hC3);
    check("full_count", b3.count, 3);
    check("full_pout",  b3.pout,  8'hC1);
    #3 rst = 1'b0;
    #1;
    check("async_pout",  b3.pout,  8'hA5);
    check("async_vout",  b3.vout,  0);
    check("async_count", b3.count, 0);
    @(negedge clk) rst = 1'b1;
    drive3(1,0,1,8'h5A);
    check("post_rst_count", b3.count, 1);
    check("post_rst_vout",  b3.vout,  0);

    // DEPTH=1: one edge of latency
    b1.ld = 1; b1.vin = 1; b1.pin = 8'h9E;
    @(posedge clk);
    #1;
    check("d1_pout",  b1.pout,  8'h9E);
    check("d1_vout",  b1.vout,  1);
    check("d1_count", b1.count, 1);

    // random run against reference queue models
    begin
      logic       ld, fl, vin;
      logic [7:0] pin;
      logic       m1v;
      logic [7:0] m1d;
      int         pc;
      drive3(0,1,0,8'h00);
      b1.flush = 1; b1.ld = 0;
      @(posedge clk);
      #1;
      mq = {};
      for (int i = 0; i < 3; i++) mq.push_back('{v:1'b0, d:8'hA5});
      m1v = 1'b0; m1d = 8'h3C;
      for (int c = 0; c < 10000; c++) begin
        fl  = ($urandom_range(15) == 0);
        ld  = ($urandom_range(3) != 0);
        vin = $urandom_range(1);
        pin = 8'($urandom);
        b1.ld = ld; b1.flush = fl; b1.vin = vin; b1.pin = pin;
        drive3(ld, fl, vin, pin);
        if (fl) begin
          mq = {};
          for (int i = 0; i < 3; i++) mq.push_back('{v:1'b0, d:8'hA5});
          m1v = 1'b0; m1d = 8'h3C;
        end else if (ld) begin
          mq.push_front('{v:vin, d:pin});
          void'(mq.pop_back());
          m1v = vin; m1d = pin;
        end
        pc = 0;
        foreach (mq[i]) pc += int'(mq[i].v);
        if (b3.pout !== mq[2].d || b3.vout !== mq[2].v || int'(b3.count) != pc || b3.count > 3) begin
          check($sformatf("rnd%0d_d3", c), {b3.count, b3.vout, b3.pout}, {2'(pc), mq[2].v, mq[2].d});
        end else n_vec++;
        if (b1.pout !== m1d || b1.vout !== m1v || b1.count !== b1.vout) begin
          check($sformatf("rnd%0d_d1", c), {b1.count, b1.vout, b1.pout}, {m1v, m1v, m1d});
        end else n_vec++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
